// File: rtl/id_ex_if.sv
// ID->EX stage handshake and payload bundle.
// The master modport is the decode/execute environment; the slave modport is the stage register.
interface id_ex_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 6,
    parameter int unsigned OP_W   = 4,
    parameter int unsigned CTRL_W = 8
);
    logic              id_valid;
    logic              id_ready;
    logic [OP_W-1:0]   id_opcode;
    logic [CTRL_W-1:0] id_ctrl;
    logic [REG_W-1:0]  id_rd;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [DATA_W-1:0] id_imm;
    logic              flush;
    logic              ex_ready;
    logic              ex_valid;
    logic [OP_W-1:0]   ex_opcode;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [REG_W-1:0]  ex_rd;
    logic [DATA_W-1:0] ex_a;
    logic [DATA_W-1:0] ex_b;

    modport master (
        output id_valid, id_opcode, id_ctrl, id_rd, id_rs_data, id_rt_data, id_imm,
        output flush, ex_ready,
        input  id_ready, ex_valid, ex_opcode, ex_ctrl, ex_rd, ex_a, ex_b
    );

    modport slave (
        input  id_valid, id_opcode, id_ctrl, id_rd, id_rs_data, id_rt_data, id_imm,
        input  flush, ex_ready,
        output id_ready, ex_valid, ex_opcode, ex_ctrl, ex_rd, ex_a, ex_b
    );
endinterface

// File: rtl/id_ex_buffer.sv
// ID->EX pipeline stage register with valid/ready handshake, flush and registered B-operand mux.
// Define IDEX_PERF_EN to build the saturating bubble-cycle counter on perf_bubbles.
module id_ex_buffer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 6,
    parameter int unsigned OP_W   = 4,
    parameter int unsigned CTRL_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    id_ex_if.slave      bus,
    output logic [15:0] perf_bubbles
);
    logic              valid_q, valid_d;
    logic [OP_W-1:0]   opcode_q, opcode_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [REG_W-1:0]  rd_q, rd_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              ready;

    assign ready = bus.ex_ready | ~valid_q;

    always_comb begin
        valid_d  = valid_q;
        opcode_d = opcode_q;
        ctrl_d   = ctrl_q;
        rd_d     = rd_q;
        a_d      = a_q;
        b_d      = b_q;
        if (bus.flush) begin
            // Operand data is left in place; only the control side is squashed.
            valid_d  = 1'b0;
            opcode_d = '0;
            ctrl_d   = '0;
            rd_d     = '0;
        end else if (ready) begin
            valid_d = bus.id_valid;
            if (bus.id_valid) begin
                opcode_d = bus.id_opcode;
                ctrl_d   = bus.id_ctrl;
                rd_d     = bus.id_rd;
                a_d      = bus.id_rs_data;
                b_d      = bus.id_ctrl[0] ? bus.id_imm : bus.id_rt_data;
            end else begin
                ctrl_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            opcode_q <= '0;
            ctrl_q   <= '0;
            rd_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            valid_q  <= valid_d;
            opcode_q <= opcode_d;
            ctrl_q   <= ctrl_d;
            rd_q     <= rd_d;
            a_q      <= a_d;
            b_q      <= b_d;
        end
    end

    assign bus.id_ready  = ready;
    assign bus.ex_valid  = valid_q;
    assign bus.ex_opcode = opcode_q;
    assign bus.ex_ctrl   = ctrl_q;
    assign bus.ex_rd     = rd_q;
    assign bus.ex_a      = a_q;
    assign bus.ex_b      = b_q;

`ifdef IDEX_PERF_EN
    logic [15:0] perf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else if (!valid_d && perf_q != 16'hFFFF) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign perf_bubbles = perf_q;
`else
    assign perf_bubbles = 16'h0000;
`endif
endmodule

// File: tb/tb_id_ex_buffer.sv
// Directed self-checking bench for id_ex_buffer: reset, operand mux, stall, flush, streaming,
// and the bubble counter (checked as saturating when IDEX_PERF_EN is defined, else as zero).
module tb_id_ex_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] perf_bubbles;
    int          checks = 0;
    int          errors = 0;
    int          pulses;

    id_ex_if #(.DATA_W(32), .REG_W(6), .OP_W(4), .CTRL_W(8)) bus ();

    id_ex_buffer #(.DATA_W(32), .REG_W(6), .OP_W(4), .CTRL_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .perf_bubbles (perf_bubbles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [7:0] ctrl,
                         input logic [5:0] rd, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] imm);
        bus.id_valid   = v;
        bus.id_opcode  = op;
        bus.id_ctrl    = ctrl;
        bus.id_rd      = rd;
        bus.id_rs_data = rs;
        bus.id_rt_data = rt;
        bus.id_imm     = imm;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [3:0] op,
                           input logic [7:0] ctrl, input logic [5:0] rd, input logic [31:0] a,
                           input logic [31:0] b);
        chk({tag, ".valid"}, {31'b0, bus.ex_valid}, {31'b0, v});
        chk({tag, ".opcode"}, {28'b0, bus.ex_opcode}, {28'b0, op});
        chk({tag, ".ctrl"}, {24'b0, bus.ex_ctrl}, {24'b0, ctrl});
        chk({tag, ".rd"}, {26'b0, bus.ex_rd}, {26'b0, rd});
        chk({tag, ".a"}, bus.ex_a, a);
        chk({tag, ".b"}, bus.ex_b, b);
    endtask

    initial begin
        // Reset held two cycles while decode offers an instruction.
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.ex_ready = 1'b1;
        drive(1'b1, 4'h3, 8'h03, 6'd7, 32'h1234_5678, 32'h8765_4321, 32'h0000_0011);
        step();
        step();
        chk_out("reset", 1'b0, 4'h0, 8'h00, 6'd0, 32'h0, 32'h0);
        chk("reset.perf", {16'b0, perf_bubbles}, 32'h0);
        chk("reset.id_ready", {31'b0, bus.id_ready}, 32'd1);

        // Operand B mux: immediate vs rt data.
        rst = 1'b0;
        drive(1'b1, 4'h3, 8'h01, 6'd5, 32'h1111_1111, 32'hDEAD_BEEF, 32'h0000_003F);
        step();
        chk_out("imm_sel", 1'b1, 4'h3, 8'h01, 6'd5, 32'h1111_1111, 32'h0000_003F);
        bus.id_ctrl = 8'h02;
        step();
        chk_out("rt_sel", 1'b1, 4'h3, 8'h02, 6'd5, 32'h1111_1111, 32'hDEAD_BEEF);

        // Stall: A held for three cycles while B waits upstream.
        drive(1'b1, 4'h7, 8'h02, 6'd9, 32'h0000_AAAA, 32'h0000_A0A0, 32'h0000_0001);
        step();
        chk_out("load_a", 1'b1, 4'h7, 8'h02, 6'd9, 32'h0000_AAAA, 32'h0000_A0A0);
        bus.ex_ready = 1'b0;
        drive(1'b1, 4'h8, 8'h03, 6'd10, 32'h0000_BBBB, 32'h0000_B0B0, 32'h0000_0011);
        #1;
        chk("stall.id_ready", {31'b0, bus.id_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("stall_hold", 1'b1, 4'h7, 8'h02, 6'd9, 32'h0000_AAAA, 32'h0000_A0A0);
            chk("stall.id_ready_hold", {31'b0, bus.id_ready}, 32'd0);
        end
        bus.ex_ready = 1'b1;
        #1;
        chk("release.id_ready", {31'b0, bus.id_ready}, 32'd1);
        step();
        chk_out("load_b", 1'b1, 4'h8, 8'h03, 6'd10, 32'h0000_BBBB, 32'h0000_0011);

        // Empty load: bubble clears control, operand data holds.
        bus.id_valid = 1'b0;
        step();
        chk_out("bubble", 1'b0, 4'h8, 8'h00, 6'd10, 32'h0000_BBBB, 32'h0000_0011);
        chk("bubble.id_ready", {31'b0, bus.id_ready}, 32'd1);

        // Flush beats stall and a simultaneous valid instruction.
        drive(1'b1, 4'h4, 8'h02, 6'd4, 32'h0000_000C, 32'h0000_00CC, 32'h0000_0002);
        step();
        chk_out("load_c", 1'b1, 4'h4, 8'h02, 6'd4, 32'h0000_000C, 32'h0000_00CC);
        bus.ex_ready = 1'b0;
        bus.flush = 1'b1;
        drive(1'b1, 4'h5, 8'h03, 6'd6, 32'h0000_000D, 32'h0000_00DD, 32'h0000_0003);
        step();
        chk_out("flush", 1'b0, 4'h0, 8'h00, 6'd0, 32'h0000_000C, 32'h0000_00CC);

        // Flush together with reset yields reset values.
        bus.flush = 1'b0;
        bus.ex_ready = 1'b1;
        step();
        chk_out("load_d", 1'b1, 4'h5, 8'h03, 6'd6, 32'h0000_000D, 32'h0000_0003);
        bus.flush = 1'b1;
        rst = 1'b1;
        step();
        chk_out("flush_rst", 1'b0, 4'h0, 8'h00, 6'd0, 32'h0, 32'h0);
        bus.flush = 1'b0;
        rst = 1'b0;

        // Stream 100 back-to-back instructions.
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            logic [31:0] iv;
            iv = i;
            drive(1'b1, iv[3:0], iv[7:0], iv[5:0], iv * 3 + 1, ~iv, iv & 32'h3F);
            step();
            if (bus.ex_valid && bus.ex_ready) pulses++;
            chk_out("stream", 1'b1, iv[3:0], iv[7:0], iv[5:0], iv * 3 + 1,
                    iv[0] ? (iv & 32'h3F) : ~iv);
        end
        bus.id_valid = 1'b0;
        step();
        chk("stream.end_valid", {31'b0, bus.ex_valid}, 32'd0);
        chk("stream.pulses", pulses, 32'd100);

        // Bubble counter: five idle cycles after reset.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
`ifdef IDEX_PERF_EN
        chk("perf.idle5", {16'b0, perf_bubbles}, 32'd5);
        repeat (70000) @(posedge clk);
        #1;
        chk("perf.saturate", {16'b0, perf_bubbles}, 32'h0000_FFFF);
        step();
        chk("perf.saturate_hold", {16'b0, perf_bubbles}, 32'h0000_FFFF);
        rst = 1'b1;
        step();
        chk("perf.rst_clear", {16'b0, perf_bubbles}, 32'h0);
        rst = 1'b0;
`else
        chk("perf.disabled", {16'b0, perf_bubbles}, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
